// File: rtl/pch_branch_unit.sv
// ---------------------------------------------------------------------------
// pch_branch_unit
//
// Program Counter High register with taken-branch page-crossing fixup.
// Every enabled falling edge of the phi2 clock loads PCH from the selected
// source plus the PCL incrementer carry. When a taken branch carries or
// borrows out of PCL, the unit spends exactly one enabled cycle in FIX,
// owning PCH, and then steps PCH by +1 or -1 according to the latched
// offset sign. DONE marks the cycle after the fixup.
//
// Optional feature (macro PCH_FIX_COUNT_EN):
//   defined   - o_fix_count counts FIX->DONE transitions, saturating at FF
//   undefined - no counter register, o_fix_count is tied to 00
//
// Ports:
//   i_clk           phi2 clock, all state changes on the falling edge
//   i_reset_n       asynchronous active-low reset
//   i_clk_en        clock enable; state holds when low
//   i_pch_pch       PCH select: recirculate current PCH (priority)
//   i_adh_pch       PCH select: take ADH bus
//   i_adh[7:0]      ADH bus
//   i_pclc          carry out of the PCL incrementer
//   i_branch        taken-branch strobe (offset already added to PCL)
//   i_branch_neg    branch offset sign, 1 = negative
//   i_branch_cross  PCL offset add crossed a page
//   o_pch[7:0]      Program Counter High
//   o_fix_busy      high in FIX; CPU must stall
//   o_fix_done      high in DONE
//   o_fix_count     fixup counter (see above)
//   o_dbg_state     raw state register, for checkers (0 IDLE, 1 FIX, 2 DONE)
//
// This unit has no valid/ready handshake: i_branch is a single-cycle
// strobe sampled on an enabled edge, and o_fix_busy tells the CPU to hold
// off for the one FIX cycle.
// ---------------------------------------------------------------------------
module pch_branch_unit (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_clk_en,
    input  logic       i_pch_pch,
    input  logic       i_adh_pch,
    input  logic [7:0] i_adh,
    input  logic       i_pclc,
    input  logic       i_branch,
    input  logic       i_branch_neg,
    input  logic       i_branch_cross,
    output logic [7:0] o_pch,
    output logic       o_fix_busy,
    output logic       o_fix_done,
    output logic [7:0] o_fix_count,
    output logic [1:0] o_dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FIX  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state_q, state_nxt;
    logic [7:0] pch_q, pch_nxt;
    logic       neg_q, neg_nxt;
    logic [7:0] pch_sel;
    logic [7:0] pch_norm;

    // Source select and incrementer carry for the ordinary update.
    always_comb begin
        if (i_pch_pch) begin
            pch_sel = pch_q;
        end else if (i_adh_pch) begin
            pch_sel = i_adh;
        end else begin
            pch_sel = 8'h00;
        end
        pch_norm = pch_sel + {7'd0, i_pclc};
    end

    // State register together with PCH and the latched branch sign.
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= S_IDLE;
            pch_q   <= 8'h00;
            neg_q   <= 1'b0;
        end else if (i_clk_en) begin
            state_q <= state_nxt;
            pch_q   <= pch_nxt;
            neg_q   <= neg_nxt;
        end
    end

    // Next-state and next-PCH logic. In FIX every bus/control input is
    // ignored: the sequencer alone decides the new PCH.
    always_comb begin
        state_nxt = S_IDLE;
        pch_nxt   = pch_norm;
        neg_nxt   = neg_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                pch_nxt = pch_norm;
                if (i_branch && i_branch_cross) begin
                    state_nxt = S_FIX;
                    neg_nxt   = i_branch_neg;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_FIX: begin
                pch_nxt   = neg_q ? (pch_q - 8'd1) : (pch_q + 8'd1);
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
                pch_nxt   = pch_q;
            end
        endcase
    end

    // Outputs decoded from registers only.
    always_comb begin
        o_pch       = pch_q;
        o_fix_busy  = (state_q == S_FIX);
        o_fix_done  = (state_q == S_DONE);
        o_dbg_state = state_q;
    end

`ifdef PCH_FIX_COUNT_EN
    logic [7:0] fix_count_q;

    // FIX always leaves to DONE on its enabled edge, so that edge is the
    // FIX->DONE transition.
    always_ff @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fix_count_q <= 8'h00;
        end else if (i_clk_en && (state_q == S_FIX) && (fix_count_q != 8'hFF)) begin
            fix_count_q <= fix_count_q + 8'd1;
        end
    end

    assign o_fix_count = fix_count_q;
`else
    assign o_fix_count = 8'h00;
`endif

endmodule

// File: tb/tb_pch_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_pch_branch_unit
//
// Directed bench for pch_branch_unit. A behavioural model tracks PCH as a
// number plus a "fixup pending" flag; a compare process checks the DUT
// against it on every rising clock edge (midway between active falling
// edges). Directed steps add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_pch_branch_unit;

    // ---------------- clock / reset ----------------
    logic       i_clk = 1'b0;
    logic       i_reset_n;
    logic       i_clk_en;
    logic       i_pch_pch;
    logic       i_adh_pch;
    logic [7:0] i_adh;
    logic       i_pclc;
    logic       i_branch;
    logic       i_branch_neg;
    logic       i_branch_cross;
    logic [7:0] o_pch;
    logic       o_fix_busy;
    logic       o_fix_done;
    logic [7:0] o_fix_count;
    logic [1:0] o_dbg_state;

    always #5 i_clk = ~i_clk;

    pch_branch_unit dut (
        .i_clk          (i_clk),
        .i_reset_n      (i_reset_n),
        .i_clk_en       (i_clk_en),
        .i_pch_pch      (i_pch_pch),
        .i_adh_pch      (i_adh_pch),
        .i_adh          (i_adh),
        .i_pclc         (i_pclc),
        .i_branch       (i_branch),
        .i_branch_neg   (i_branch_neg),
        .i_branch_cross (i_branch_cross),
        .o_pch          (o_pch),
        .o_fix_busy     (o_fix_busy),
        .o_fix_done     (o_fix_done),
        .o_fix_count    (o_fix_count),
        .o_dbg_state    (o_dbg_state)
    );

    int checks   = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    // Expected counter value after n fixups since reset.
    function automatic logic [7:0] exp_cnt(input int n);
`ifdef PCH_FIX_COUNT_EN
        return (n > 255) ? 8'hFF : n[7:0];
`else
        return 8'h00;
`endif
    endfunction

    // ---------------- behavioural model ----------------
    // m_pending: a page-crossing branch was accepted and PCH still owes
    // its +/-1 step. m_after: the step was applied on the last enabled edge.
    logic [7:0] m_pch;
    logic       m_pending;
    logic       m_after;
    logic       m_neg;
    int         m_fixups;

    always @(negedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            m_pch     <= 8'h00;
            m_pending <= 1'b0;
            m_after   <= 1'b0;
            m_neg     <= 1'b0;
            m_fixups  <= 0;
        end else if (i_clk_en) begin
            if (m_pending) begin
                m_pch     <= m_neg ? m_pch - 8'd1 : m_pch + 8'd1;
                m_pending <= 1'b0;
                m_after   <= 1'b0 | 1'b1;
                m_fixups  <= m_fixups + 1;
            end else begin
                m_pch   <= (i_pch_pch ? m_pch : (i_adh_pch ? i_adh : 8'h00)) + {7'd0, i_pclc};
                m_after <= 1'b0;
                if (i_branch && i_branch_cross) begin
                    m_pending <= 1'b1;
                    m_neg     <= i_branch_neg;
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(posedge i_clk) begin
        if (chk_en) begin
            checks = checks + 1;
            if (o_pch !== m_pch) begin
                failures = failures + 1;
                $display("FAIL cmp_pch t=%0t actual=%02h expected=%02h", $time, o_pch, m_pch);
            end
            checks = checks + 1;
            if ((o_fix_busy !== m_pending) || (o_fix_done !== m_after)) begin
                failures = failures + 1;
                $display("FAIL cmp_flags t=%0t actual busy=%b done=%b expected busy=%b done=%b",
                         $time, o_fix_busy, o_fix_done, m_pending, m_after);
            end
            checks = checks + 1;
            if (o_fix_count !== exp_cnt(m_fixups)) begin
                failures = failures + 1;
                $display("FAIL cmp_count t=%0t actual=%02h expected=%02h",
                         $time, o_fix_count, exp_cnt(m_fixups));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%02h expected=%02h", name, act, exp);
        end
    endtask

    // One active (falling) edge; outputs are settled 1 time unit later.
    task automatic cyc();
        @(negedge i_clk);
        #1;
    endtask

    task automatic set_sel(input logic pp, input logic ap, input logic [7:0] adh, input logic pc);
        i_pch_pch = pp;
        i_adh_pch = ap;
        i_adh     = adh;
        i_pclc    = pc;
    endtask

    task automatic set_br(input logic br, input logic cr, input logic ng);
        i_branch       = br;
        i_branch_cross = cr;
        i_branch_neg   = ng;
    endtask

    // Load PCH from ADH with no carry.
    task automatic load_pch(input logic [7:0] v);
        set_sel(1'b0, 1'b1, v, 1'b0);
        set_br(1'b0, 1'b0, 1'b0);
        cyc();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        i_clk_en = 1'b1;
        set_sel(1'b0, 1'b0, 8'h00, 1'b0);
        set_br(1'b0, 1'b0, 1'b0);
        #1;
        i_reset_n = 1'b0;
        #1;
        chk_en = 1'b1;
        chk("reset_pch", o_pch, 8'h00);
        chk("reset_busy_done", {6'd0, o_fix_busy, o_fix_done}, 8'h00);
        chk("reset_count", o_fix_count, 8'h00);
        cyc();
        cyc();
        i_reset_n = 1'b1;

        // Increment from 00 three times.
        set_sel(1'b1, 1'b0, 8'h00, 1'b1);
        cyc(); chk("inc1", o_pch, 8'h01);
        cyc(); chk("inc2", o_pch, 8'h02);
        cyc(); chk("inc3", o_pch, 8'h03);
        chk("inc_busy_done", {6'd0, o_fix_busy, o_fix_done}, 8'h00);

        // ADH source with wrap, then plain ADH load.
        set_sel(1'b0, 1'b1, 8'hFF, 1'b1);
        cyc(); chk("adh_wrap", o_pch, 8'h00);
        set_sel(1'b0, 1'b1, 8'h12, 1'b0);
        cyc(); chk("adh_load", o_pch, 8'h12);

        // Positive crossing branch; inputs during FIX must be ignored.
        set_sel(1'b1, 1'b0, 8'h00, 1'b0);
        set_br(1'b1, 1'b1, 1'b0);
        cyc(); chk("pos_fix_pch", o_pch, 8'h12);
        chk("pos_fix_busy", {7'd0, o_fix_busy}, 8'h01);
        set_sel(1'b0, 1'b1, 8'hAA, 1'b1);
        set_br(1'b1, 1'b1, 1'b1);
        cyc(); chk("pos_done_pch", o_pch, 8'h13);
        chk("pos_done_flags", {6'd0, o_fix_busy, o_fix_done}, 8'h01);
        chk("pos_count", o_fix_count, exp_cnt(1));
        set_sel(1'b1, 1'b0, 8'h00, 1'b0);
        set_br(1'b0, 1'b0, 1'b0);
        cyc(); chk("pos_idle_pch", o_pch, 8'h13);
        chk("pos_idle_flags", {6'd0, o_fix_busy, o_fix_done}, 8'h00);

        // Negative crossing branch from 00 with clock enable gaps in FIX.
        load_pch(8'h00);
        set_sel(1'b1, 1'b0, 8'h00, 1'b0);
        set_br(1'b1, 1'b1, 1'b1);
        cyc(); chk("neg_fix_busy", {7'd0, o_fix_busy}, 8'h01);
        set_br(1'b0, 1'b0, 1'b0);
        i_clk_en = 1'b0;
        cyc(); chk("neg_hold1", o_pch, 8'h00);
        cyc(); chk("neg_hold2", o_pch, 8'h00);
        chk("neg_hold_busy", {7'd0, o_fix_busy}, 8'h01);
        i_clk_en = 1'b1;
        cyc(); chk("neg_wrap", o_pch, 8'hFF);
        chk("neg_done", {6'd0, o_fix_busy, o_fix_done}, 8'h01);
        chk("neg_count", o_fix_count, exp_cnt(2));
        cyc(); chk("neg_idle", {6'd0, o_fix_busy, o_fix_done}, 8'h00);

        // Reset in the middle of FIX abandons the fixup.
        load_pch(8'h40);
        set_sel(1'b1, 1'b0, 8'h00, 1'b0);
        set_br(1'b1, 1'b1, 1'b0);
        cyc(); chk("rst_fix_pch", o_pch, 8'h40);
        set_br(1'b0, 1'b0, 1'b0);
        #2;
        i_reset_n = 1'b0;
        #1;
        chk("rst_async_pch", o_pch, 8'h00);
        chk("rst_async_busy", {7'd0, o_fix_busy}, 8'h00);
        cyc();
        i_reset_n = 1'b1;
        cyc(); chk("rst_after_pch", o_pch, 8'h00);
        chk("rst_after_flags", {6'd0, o_fix_busy, o_fix_done}, 8'h00);
        chk("rst_after_count", o_fix_count, 8'h00);

        // Crossing branch issued while in DONE goes straight back to FIX.
        load_pch(8'h20);
        set_sel(1'b1, 1'b0, 8'h00, 1'b0);
        set_br(1'b1, 1'b1, 1'b0);
        cyc(); chk("dd_fix1", {7'd0, o_fix_busy}, 8'h01);
        set_br(1'b0, 1'b0, 1'b0);
        cyc(); chk("dd_pch1", o_pch, 8'h21);
        chk("dd_done1", {7'd0, o_fix_done}, 8'h01);
        set_br(1'b1, 1'b1, 1'b1);
        cyc(); chk("dd_fix2", {6'd0, o_fix_busy, o_fix_done}, 8'h02);
        set_br(1'b0, 1'b0, 1'b0);
        cyc(); chk("dd_pch2", o_pch, 8'h20);
        chk("dd_count", o_fix_count, exp_cnt(2));
        cyc(); chk("dd_idle", {6'd0, o_fix_busy, o_fix_done}, 8'h00);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
